// File: rtl/data_upload.sv
// SPI-side upload engine: answers FILE_RX commands by prefetching bytes from
// external RAM and shifting them out on sdo, all in the system clock domain.
`timescale 1ns/1ps
module data_upload #(
    parameter logic [24:0] BASE0    = 25'h0010000,
    parameter logic [24:0] BASE2    = 25'h0100000,
    parameter logic [24:0] BASE_DEF = 25'h0000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sck,
    input  logic        ss,
    input  logic        sdi,
    output logic        sdo,
    output logic        uploading,
    output logic [4:0]  index,
    output logic        rd,
    output logic [24:0] a,
    input  logic [7:0]  q,
    input  logic        ready,
    output logic        underrun
);

    localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;
    localparam logic [7:0] CMD_FILE_RX     = 8'h56;
    localparam logic [7:0] CMD_FILE_RX_DAT = 8'h57;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FULL = 2'd2
    } fetch_state_t;

    logic [1:0]   sck_sync_r, ss_sync_r, sdi_sync_r;
    logic         sck_prev_r;
    logic [3:0]   cnt_r;
    logic [6:0]   rx_sh_r;
    logic [7:0]   cmd_r;
    logic         load_pend_r;
    logic [7:0]   shifter_r;
    logic         sdo_r;
    logic         uploading_r;
    logic [4:0]   index_r;
    logic         rd_r;
    logic [24:0]  a_r;
    logic [7:0]   buf_r;
    logic         underrun_r;
    fetch_state_t state_r, state_nxt_s;

    logic         sck_s, ss_s, sdi_s, sck_rise_s, sck_fall_s;
    logic [7:0]   rx_byte_s;
    logic         byte_done_s, start_s, stop_s, idx_s, load_s, load_hit_s;
    logic [24:0]  base_s;

    assign sck_s       = sck_sync_r[1];
    assign ss_s        = ss_sync_r[1];
    assign sdi_s       = sdi_sync_r[1];
    assign sck_rise_s  = sck_s & ~sck_prev_r;
    assign sck_fall_s  = ~sck_s & sck_prev_r;
    assign rx_byte_s   = {rx_sh_r, sdi_s};
    assign byte_done_s = ~ss_s & sck_rise_s & (cnt_r == 4'd15);
    assign start_s     = byte_done_s & (cmd_r == CMD_FILE_RX) & rx_byte_s[0];
    assign stop_s      = byte_done_s & (cmd_r == CMD_FILE_RX) & ~rx_byte_s[0];
    assign idx_s       = byte_done_s & (cmd_r == CMD_FILE_INDEX);
    assign load_s      = ~ss_s & sck_fall_s & load_pend_r
                         & (cmd_r == CMD_FILE_RX_DAT) & uploading_r;
    assign load_hit_s  = load_s & (state_r == ST_FULL);

    // Start address selection from the last received menu index
    always_comb begin
        base_s = BASE_DEF;
        case (index_r)
            5'd0:    base_s = BASE0;
            5'd2:    base_s = BASE2;
            default: base_s = BASE_DEF;
        endcase
    end

    // Pin synchronizers and sck edge history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_r <= 2'b00;
            ss_sync_r  <= 2'b11;
            sdi_sync_r <= 2'b00;
            sck_prev_r <= 1'b0;
        end else begin
            sck_sync_r <= {sck_sync_r[0], sck};
            ss_sync_r  <= {ss_sync_r[0], ss};
            sdi_sync_r <= {sdi_sync_r[0], sdi};
            sck_prev_r <= sck_s;
        end
    end

    // Bit counter, command capture and output shifter; ss high beats any sck edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r       <= 4'd0;
            rx_sh_r     <= 7'd0;
            cmd_r       <= 8'h00;
            load_pend_r <= 1'b0;
            shifter_r   <= 8'h00;
            sdo_r       <= 1'b0;
        end else begin
            sdo_r <= ss_s ? 1'b0 : shifter_r[7];
            if (ss_s) begin
                cnt_r       <= 4'd0;
                rx_sh_r     <= 7'd0;
                load_pend_r <= 1'b0;
                shifter_r   <= 8'h00;
            end else if (sck_rise_s) begin
                rx_sh_r <= rx_byte_s[6:0];
                if (cnt_r == 4'd7) begin
                    cmd_r       <= rx_byte_s;
                    cnt_r       <= 4'd8;
                    load_pend_r <= 1'b1;
                end else if (cnt_r == 4'd15) begin
                    cnt_r       <= 4'd8;
                    load_pend_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + 4'd1;
                end
            end else if (sck_fall_s) begin
                if (load_pend_r) begin
                    load_pend_r <= 1'b0;
                    if (load_s) begin
                        shifter_r <= (state_r == ST_FULL) ? buf_r : 8'hFF;
                    end else begin
                        shifter_r <= 8'h00;
                    end
                end else begin
                    shifter_r <= {shifter_r[6:0], 1'b0};
                end
            end
        end
    end

    // Fetch FSM next state; a start or end command overrides the fetch progress
    always_comb begin
        state_nxt_s = state_r;
        if (start_s) begin
            state_nxt_s = ST_REQ;
        end else if (stop_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_IDLE;
                ST_REQ:  state_nxt_s = ready  ? ST_FULL : ST_REQ;
                ST_FULL: state_nxt_s = load_s ? ST_REQ  : ST_FULL;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Fetch state, session flags, address and prefetch buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            rd_r        <= 1'b0;
            uploading_r <= 1'b0;
            underrun_r  <= 1'b0;
            index_r     <= 5'd0;
            a_r         <= 25'd0;
            buf_r       <= 8'h00;
        end else begin
            state_r <= state_nxt_s;
            rd_r    <= (state_nxt_s == ST_REQ);
            if (idx_s) begin
                index_r <= rx_byte_s[4:0];
            end
            if (start_s) begin
                uploading_r <= 1'b1;
                underrun_r  <= 1'b0;
                a_r         <= base_s;
            end else if (stop_s) begin
                uploading_r <= 1'b0;
            end else begin
                if (load_hit_s) begin
                    a_r <= a_r + 25'd1;
                end
                if (load_s && (state_r != ST_FULL)) begin
                    underrun_r <= 1'b1;
                end
            end
            // A ready landing with an underrun load still fills the buffer for the retry
            if ((state_r == ST_REQ) && ready && !start_s && !stop_s) begin
                buf_r <= q;
            end
        end
    end

    assign sdo       = sdo_r;
    assign uploading = uploading_r;
    assign index     = index_r;
    assign rd        = rd_r;
    assign a         = a_r;
    assign underrun  = underrun_r;

endmodule

// File: tb/tb_data_upload.sv
// Directed bench for data_upload: SPI controller tasks, a RAM model answering
// q = a[7:0]^0xA5 after a programmable delay, and a log of every rd request.
`timescale 1ns/1ps
module tb_data_upload;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sck = 1'b0;
    logic        ss = 1'b1;
    logic        sdi = 1'b0;
    logic        sdo, uploading, rd, underrun;
    logic [4:0]  index;
    logic [24:0] a;
    logic [7:0]  q = 8'h00;
    logic        ready = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          ram_delay = 2;
    logic [24:0] rd_addr_q[$];
    logic [7:0]  rx_buf[8];

    logic        ram_busy = 1'b0;
    int          ram_wait = 0;
    logic [24:0] ram_addr = 25'd0;
    logic        rd_prev = 1'b0;

    data_upload #(.BASE_DEF(25'h1FFFFFF)) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
        .sdo(sdo), .uploading(uploading), .index(index), .rd(rd), .a(a),
        .q(q), .ready(ready), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // RAM model: a delayed one-cycle ready pulse; it keeps running if rd drops
    always @(negedge clk) begin
        if (!reset_n) begin
            ready = 1'b0;
            ram_busy = 1'b0;
        end else if (ready) begin
            ready = 1'b0;
        end else if (ram_busy) begin
            if (ram_wait <= 1) begin
                ready = 1'b1;
                q = ram_addr[7:0] ^ 8'hA5;
                ram_busy = 1'b0;
            end else begin
                ram_wait = ram_wait - 1;
            end
        end else if (rd) begin
            ram_busy = 1'b1;
            ram_addr = a;
            ram_wait = ram_delay;
        end
    end

    // Request log: address seen at each rising edge of rd
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_prev = 1'b0;
        end else begin
            if (rd && !rd_prev) rd_addr_q.push_back(a);
            rd_prev = rd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sdi = tx[7-i];
            #80;
            rx[7-i] = sdo;
            sck = 1'b1;
            #80;
            sck = 1'b0;
        end
    endtask

    task automatic ss_begin();
        ss = 1'b0;
        #80;
    endtask

    task automatic ss_end();
        #80;
        ss = 1'b1;
        #200;
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [7:0] d, input int n);
        logic [7:0] r;
        ss_begin();
        spi_bits(cmd, 8, r);
        for (int i = 0; i < n; i++) begin
            spi_bits(d, 8, r);
            rx_buf[i] = r;
        end
        ss_end();
    endtask

    initial begin
        logic [7:0] r;
        int         qn;
        int         k;

        // Reset held with random pin activity
        repeat (40) begin
            @(negedge clk);
            {sck, ss, sdi} = 3'($urandom_range(0, 7));
        end
        check("rst_sdo", sdo, 1'b0);
        check("rst_uploading", uploading, 1'b0);
        check("rst_index", index, 5'd0);
        check("rst_rd", rd, 1'b0);
        check("rst_a", a, 25'd0);
        check("rst_underrun", underrun, 1'b0);
        sck = 1'b0; ss = 1'b1; sdi = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #200;

        // Index 0 read-back
        xfer(8'h55, 8'h00, 1);
        check("idx0_index", index, 5'd0);
        check("no_rd_before_start", rd_addr_q.size(), 0);
        xfer(8'h56, 8'h01, 1);
        check("start_uploading", uploading, 1'b1);
        check("start_one_req", rd_addr_q.size(), 1);
        check("idx0_first_a", rd_addr_q[0], 25'h0010000);
        xfer(8'h57, 8'h00, 4);
        check("idx0_b0", rx_buf[0], 8'hA5);
        check("idx0_b1", rx_buf[1], 8'hA4);
        check("idx0_b2", rx_buf[2], 8'hA7);
        check("idx0_b3", rx_buf[3], 8'hA6);
        check("sdo_idle", sdo, 1'b0);
        check("idx0_underrun", underrun, 1'b0);
        xfer(8'h12, 8'hFF, 1);
        check("other_cmd_sdo", rx_buf[0], 8'h00);

        // Index 2, end while a read is outstanding
        xfer(8'h55, 8'h02, 1);
        check("idx2_index", index, 5'd2);
        xfer(8'h56, 8'h01, 1);
        check("idx2_first_a", rd_addr_q[$], 25'h0100000);
        ss_begin();
        spi_bits(8'h57, 8, r);
        spi_bits(8'h00, 8, r);
        ram_delay = 1000;
        ss_end();
        check("idx2_b0", r, 8'hA5);
        check("idx2_rd_pending", rd, 1'b1);
        xfer(8'h56, 8'h00, 1);
        check("end_uploading", uploading, 1'b0);
        check("end_rd", rd, 1'b0);
        qn = rd_addr_q.size();
        for (k = 0; k < 1200 && !ready; k++) @(posedge clk);
        check("late_ready_seen", ready, 1'b1);
        repeat (5) @(negedge clk);
        check("late_rd", rd, 1'b0);
        check("late_uploading", uploading, 1'b0);
        check("late_no_req", rd_addr_q.size(), qn);
        check("late_a", a, 25'h0100002);
        ram_delay = 2;

        // Address wrap from BASE_DEF
        xfer(8'h55, 8'h05, 1);
        qn = rd_addr_q.size();
        xfer(8'h56, 8'h01, 1);
        xfer(8'h57, 8'h00, 2);
        check("wrap_a0", rd_addr_q[qn], 25'h1FFFFFF);
        check("wrap_a1", rd_addr_q[qn+1], 25'h0000000);
        check("wrap_b0", rx_buf[0], 8'h5A);
        check("wrap_b1", rx_buf[1], 8'hA5);

        // Slow RAM: second byte misses its slot and is retried
        ram_delay = 200;
        xfer(8'h57, 8'h00, 3);
        check("slow_b0", rx_buf[0], 8'hA7);
        check("slow_b1", rx_buf[1], 8'hFF);
        check("slow_b2", rx_buf[2], 8'hA6);
        check("slow_underrun", underrun, 1'b1);
        repeat (300) @(negedge clk);
        ram_delay = 2;

        // Abort at bit 4: the loaded byte is lost, buffer is kept
        ss_begin();
        spi_bits(8'h57, 8, r);
        spi_bits(8'h00, 4, r);
        ss_end();
        check("abort_partial", r, 8'hA0);
        xfer(8'h57, 8'h00, 1);
        check("abort_next", rx_buf[0], 8'hA0);
        check("underrun_sticky", underrun, 1'b1);

        // Reset pulse mid-byte
        ss_begin();
        spi_bits(8'h57, 8, r);
        spi_bits(8'h00, 2, r);
        check("mid_partial", r, 8'h80);
        #60;
        check("mid_sdo_high", sdo, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_sdo", sdo, 1'b0);
        check("mid_rst_rd", rd, 1'b0);
        check("mid_rst_uploading", uploading, 1'b0);
        check("mid_rst_a", a, 25'd0);
        check("mid_rst_underrun", underrun, 1'b0);
        check("mid_rst_index", index, 5'd0);
        ss = 1'b1;
        #100;
        reset_n = 1'b1;
        #200;
        check("post_rst_rd", rd, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_upload.md
# data_upload

SPI-side upload engine: the read-back counterpart of the download path. It answers IO-controller file-receive commands by fetching bytes from external RAM and shifting them out on `sdo`, so the controller can save memory images (tape/snapshot) to SD card. It sits beside the download block on the same `sck`/`ss`/`sdi` bus and shares the RAM port through the top-level arbiter. Unlike the download block, everything runs in the system clock domain, and the SPI pins are oversampled.

## Interface
Parameters:
- `BASE0`, 25'h010000: start address for index 0
- `BASE2`, 25'h100000: start address for index 2
- `BASE_DEF`, 25'h000000: start address for any other index

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, rising edge; must be >= 8x `sck` frequency
- `reset_n` in 1: async active-low reset
- `sck`, `ss`, `sdi` in 1 each: IO-controller SPI, asynchronous; synchronized internally
- `sdo` out 1: serial data to the controller, MSB first
- `uploading` out 1: upload session active
- `index` out 5: last menu index received
- `rd` out 1: RAM read request
- `a` out 25: RAM read address
- `q` in 8: RAM read data, valid when `ready`=1
- `ready` in 1: RAM read acknowledge, one-cycle pulse
- `underrun` out 1: sticky; RAM was late for a byte

## Operation
- SPI front end:
  - `sck`, `ss`, `sdi` each pass through a 2-flop synchronizer.
  - The block detects `sck` rising and falling edges on the synchronized signal.
  - `ss`=1 clears the bit counter `cnt` and the shift state.
- Bit counter (mode 0):
  - `sdi` is sampled on `sck` rising edges.
  - `cnt` counts 0..7 for the command byte, then 8..15 for each data byte, repeating 8..15.
  - The command byte latches on the rising edge at `cnt`=7.
- Commands:
  - 0x55 FILE_INDEX: at `cnt`=15, `index` <= low 5 bits of the byte.
  - 0x56 FILE_RX, data bit 0 = 1 (start):
    - `uploading` <= 1 and `underrun` <= 0.
    - Fetch address <= base selected by `index`.
    - Buffer is marked empty; fetch FSM goes to REQ.
  - 0x56 FILE_RX, data bit 0 = 0 (end):
    - `uploading` <= 0; fetch FSM goes to IDLE.
    - `rd` drops the next cycle, even if a read is outstanding.
    - A late `ready` is ignored.
  - 0x57 FILE_RX_DAT: each data byte the controller clocks receives one RAM byte on `sdo`; `sdi` is ignored.
  - Other commands: `sdo`=0 and no side effects.
- Fetch FSM (one-byte prefetch buffer `buf`):
  - IDLE: `rd`=0. Leaves only on a FILE_RX start.
  - REQ: `rd`=1 with `a` stable. On `ready`, `buf` <= `q` and go to FULL; `rd` drops the same cycle.
  - FULL: `rd`=0. When the shifter consumes `buf`: `a` <= `a`+1 (wraps 25'h1FFFFFF to 0), then go to REQ.
- Output shifter:
  - Loads on the first falling `sck` edge after the rising edge that completed `cnt`=7 or `cnt`=15, only while the command is FILE_RX_DAT and `uploading`=1.
  - Load source: `buf` if the FSM is in FULL. Otherwise 0xFF, `underrun` <= 1, and no address advance (the same byte is retried for the next slot).
  - Shifts left on each of the 7 following falling edges.
  - `sdo` = shifter bit 7 while `ss`=0; `sdo`=0 while `ss`=1.
- `ss` rising mid-byte:
  - The partial byte is abandoned; the byte already loaded is lost (counted as sent).
  - The prefetched `buf` is kept for the next transfer.

## Timing
- Reset values: `sdo`=0, `uploading`=0, `index`=0, `rd`=0, `a`=0, `underrun`=0; FSM in IDLE; `buf`=0.
- Edge latency: `sck` edge to internal edge detect is 3 `clk` cycles.
- `sdo` update: within 4 `clk` cycles of the `sck` falling edge. It is stable at the next rising edge because of the 8x ratio.
- First RAM request: `rd` asserts 1 cycle after the FILE_RX start bit is latched.
- Next request: `rd` re-asserts 1 cycle after each shifter load.
- Deadline: a byte is on time if `ready` arrives before the next load, i.e. within about 8 `sck` periods.
- Same-cycle `ready` and load: the load wins with 0xFF and sets `underrun`. `q` is then captured into `buf` for the next slot, with no duplicate request.
- Same-cycle `ss` rise and `sck` fall: `ss` wins, so no load and no shift.
- Reset mid-transfer: all state returns to reset values immediately. `rd` falls asynchronously.

## Test plan
- Reset:
  - Stimulus: hold `reset_n`=0 with random pin activity.
  - Required: all outputs at their reset values.
  - Stimulus: release reset.
  - Required: no `rd` until a FILE_RX start.
- Index 0 read-back:
  - Stimulus: 0x55/0x00, then 0x56/0x01, then 0x57 with 4 bytes clocked. RAM model returns `q`=`a`[7:0]^0xA5 after 2 cycles.
  - Required: `sdo` bytes 0xA5, 0xA4, 0xA7, 0xA6. First `a`=0x010000.
- Index 2 with end mid-fetch:
  - Stimulus: index 2, start, 1 byte, then 0x56/0x00 while `rd`=1.
  - Required: base 0x100000; `uploading`=0 and `rd`=0 within 2 cycles; a later `ready` is ignored.
- Slow RAM:
  - Stimulus: `ready` delayed past the byte deadline.
  - Required: that byte is 0xFF and `underrun`=1. The next byte carries the RAM value for the same address.
- Address wrap:
  - Stimulus: `BASE_DEF`=25'h1FFFFFF, index 5, read 2 bytes.
  - Required: `a` sequence is 0x1FFFFFF, then 0x0000000.
- Abort and reset:
  - Stimulus: `ss` rises at bit 4 of a byte; next transfer is 0x57.
  - Required: the next transfer emits the following address's byte.
  - Stimulus: `reset_n` pulses mid-byte.
  - Required: `sdo`=0 immediately.
